// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the iterative RV32M multiply/divide unit:
//   funct3 operation encodings, the FSM state type, the default datapath
//   width and the resulting fixed latency, plus small decode helpers that
//   tell which operands are treated as signed for a given operation.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    // Default operand width and the fixed start-to-done latency in cycles:
    // WIDTH iteration cycles, one FIX cycle and one DONE cycle.
    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_LAT   = MULDIV_WIDTH + 2;

    // funct3 encodings of the RV32M instructions.
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Latency for an arbitrary width, for users that override WIDTH.
    function automatic int muldiv_lat(input int width);
        return width + 2;
    endfunction

    // rs1 is treated as a signed value for MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    endfunction

    // rs2 is treated as a signed value for MULH, DIV and REM.
    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit with a fixed latency of WIDTH+2
//   cycles. Operands are captured as magnitudes on the accepting edge, a
//   shift-add multiply or restoring divide runs for WIDTH cycles, and the
//   signed/special-case result is formed in a single FIX cycle.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   start    in   request an operation (sampled only in IDLE)
//   funct3   in   operation select (MUL..REMU)
//   rs1_val  in   operand A / dividend
//   rs2_val  in   operand B / divisor
//   rd_in    in   destination register index
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse, result valid
//   we       out  register file write enable (done and rd_out != 0)
//   rd_out   out  latched destination index
//   result   out  write data, held until the next FIX
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic             we,
    output logic [4:0]       rd_out,
    output logic [WIDTH-1:0] result
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;

    logic [2:0]         op_q;        // latched funct3
    logic [4:0]         rd_q;        // latched rd_in, copied to rd_out in FIX
    logic               sign_a_q;    // rs1 was negative and treated as signed
    logic               sign_b_q;    // rs2 was negative and treated as signed
    logic [WIDTH-1:0]   a_orig_q;    // raw rs1, needed for REM by zero
    logic [2*WIDTH-1:0] opa_q;       // multiplicand (shifts left) / dividend bits
    logic [WIDTH-1:0]   opb_q;       // multiplier (shifts right) / divisor
    logic [2*WIDTH-1:0] acc_q;       // product, or {remainder, quotient}
    logic [CNT_W-1:0]   cnt_q;
    logic [4:0]         rd_out_q;
    logic [WIDTH-1:0]   result_q;

    // ------------------------------------------------------------------
    // Operand capture: magnitudes and sign flags
    // ------------------------------------------------------------------
    logic               in_sign_a;
    logic               in_sign_b;
    logic [WIDTH-1:0]   in_mag_a;
    logic [WIDTH-1:0]   in_mag_b;

    assign in_sign_a = op_signed_a(funct3) && rs1_val[WIDTH-1];
    assign in_sign_b = op_signed_b(funct3) && rs2_val[WIDTH-1];
    // The magnitude of the most negative value still fits as an unsigned.
    assign in_mag_a  = in_sign_a ? -rs1_val : rs1_val;
    assign in_mag_b  = in_sign_b ? -rs2_val : rs2_val;

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] div_step;

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first; a path that leaves a signal unassigned infers a latch.
        mul_step  = acc_q + (opb_q[0] ? opa_q : {2*WIDTH{1'b0}});

        // Restoring divide: bring down the next dividend bit, try to subtract.
        // The partial remainder is always below the divisor, so WIDTH+1 bits
        // hold the shifted value and a fitting difference fits in WIDTH bits.
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], opa_q[2*WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opb_q};
        div_fits  = ~rem_diff[WIDTH];
        div_step  = {div_fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0],
                     acc_q[WIDTH-2:0], div_fits};
    end

    // ------------------------------------------------------------------
    // FIX: sign correction, half/quotient/remainder select, special cases
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   fix_result;

    always_comb begin
        prod_signed = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_signed  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_signed  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        div_zero    = (opb_q == '0);
        // -2^(W-1) / -1: divisor magnitude 1 with a negative sign.
        div_ovf     = sign_a_q && sign_b_q && (a_orig_q == INT_MIN) && (opb_q == ONE);

        fix_result  = '0;
        case (op_q)
            F3_MUL:                       fix_result = prod_signed[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_signed[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU: begin
                if (div_zero)     fix_result = '1;
                else if (div_ovf) fix_result = INT_MIN;
                else              fix_result = quo_signed;
            end
            default: begin // F3_REM, F3_REMU
                if (div_zero)     fix_result = a_orig_q;
                else if (div_ovf) fix_result = '0;
                else              fix_result = rem_signed;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked blocks use non-blocking '<=' only, so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            op_q     <= '0;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_orig_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= funct3;
                        rd_q     <= rd_in;
                        sign_a_q <= in_sign_a;
                        sign_b_q <= in_sign_b;
                        a_orig_q <= rs1_val;
                        // Divide consumes dividend bits from the top of opa;
                        // multiply adds opa directly and shifts it left.
                        opa_q    <= op_is_div(funct3) ? {in_mag_a, {WIDTH{1'b0}}}
                                                      : {{WIDTH{1'b0}}, in_mag_a};
                        opb_q    <= in_mag_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    opa_q <= opa_q << 1;
                    if (op_is_div(op_q)) begin
                        acc_q <= div_step;
                    end else begin
                        acc_q <= mul_step;
                        opb_q <= opb_q >> 1;
                    end
                end
                FIX: begin
                    result_q <= fix_result;
                    rd_out_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign we     = done && (rd_out_q != 5'd0);
    assign rd_out = rd_out_q;
    assign result = result_q;

endmodule
